// File: rtl/sid_dac_rx_pkg.sv
// Shared constants for the SID DAC serial receiver: frame layout, field
// positions agreed with the DAC transmitter, and receive FSM encoding.
package sid_dac_rx_pkg;

   localparam int DFLT_FRAME_BITS = 16;
   localparam int SAMPLE_BITS     = 12;
   localparam int CMD_BITS        = 4;

   localparam int SAMPLE_LSB      = 0;
   localparam int CMD_LSB         = SAMPLE_LSB + SAMPLE_BITS;

   localparam int CNT_BITS        = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CLOSE = 2'd2
   } rx_state_t;

endpackage

// File: rtl/sid_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with a rising-edge
// strobe formed against one further registered copy of the synchronised value.
module sid_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic [STAGES-1:0] sync_ff;
   logic              prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff <= '0;
         prev    <= 1'b0;
      end else begin
         sync_ff[0] <= din;
         for (int i = 1; i < STAGES; i++) begin
            sync_ff[i] <= sync_ff[i-1];
         end
         prev <= sync_ff[STAGES-1];
      end
   end

   assign rise = sync_ff[STAGES-1] & ~prev;

endmodule

// File: rtl/sid_dac_rx.sv
// Two-channel serial DAC frame receiver: shifts MSB-first frames on dac_clk,
// closes them on dac_le, and presents sample/command pairs with a valid/ready hold.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no bits yet; first dac_clk edge starts a frame, dac_le alone is an error
// ST_SHIFT | collecting bits; dac_le closes, a quiet dac_clk abandons silently
// ST_CLOSE | one cycle: deliver, drop with overrun, or flag a bad bit count
module sid_dac_rx #(
   parameter int FRAME_BITS  = sid_dac_rx_pkg::DFLT_FRAME_BITS,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dac_clk,
   input  logic        dac_le,
   input  logic        dac_dat_1,
   input  logic        dac_dat_2,
   output logic [11:0] sample_1,
   output logic [11:0] sample_2,
   output logic [3:0]  cmd_1,
   output logic [3:0]  cmd_2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        frame_err,
   output logic        overrun,
   output logic [7:0]  err_count,
   input  logic        clr_status
);

   import sid_dac_rx_pkg::*;

   localparam int                  TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0]       TIMER_LOAD = TW'(TIMEOUT - 1);
   localparam logic [CNT_BITS-1:0] FRAME_CNT  = CNT_BITS'(FRAME_BITS);

   logic [1:0] rst_sync;
   logic       rst_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_sync <= 2'b00;
      else      rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_i = rst_sync[1];

   logic clk_rise;
   logic le_rise;

   sid_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
      .clk   (clk),
      .rst_n (rst_i),
      .din   (dac_clk),
      .rise  (clk_rise)
   );

   sid_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_le (
      .clk   (clk),
      .rst_n (rst_i),
      .din   (dac_le),
      .rise  (le_rise)
   );

   // Data uses the same depth as dac_clk so the bit seen on clk_rise is the
   // value that was present at the transmitter's rising edge.
   logic [1:0] dat_ff [SYNC_STAGES];
   logic       dat_1;
   logic       dat_2;

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) dat_ff[i] <= 2'b00;
      end else begin
         dat_ff[0] <= {dac_dat_2, dac_dat_1};
         for (int i = 1; i < SYNC_STAGES; i++) dat_ff[i] <= dat_ff[i-1];
      end
   end

   assign dat_1 = dat_ff[SYNC_STAGES-1][0];
   assign dat_2 = dat_ff[SYNC_STAGES-1][1];

   rx_state_t             state;
   logic [CNT_BITS-1:0]   bit_cnt;
   logic [TW-1:0]         timer;
   logic [FRAME_BITS-1:0] shift_1;
   logic [FRAME_BITS-1:0] shift_2;

   logic close_good;
   logic close_bad;
   logic overrun_set;

   assign close_good  = (state == ST_CLOSE) && (bit_cnt == FRAME_CNT);
   assign close_bad   = (state == ST_CLOSE) && (bit_cnt != FRAME_CNT);
   assign overrun_set = close_good && out_valid && !out_ready;

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         timer     <= '0;
         shift_1   <= '0;
         shift_2   <= '0;
         sample_1  <= '0;
         sample_2  <= '0;
         cmd_1     <= '0;
         cmd_2     <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         err_count <= '0;
      end else begin
         frame_err <= 1'b0;
         if (out_valid && out_ready) out_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               bit_cnt <= '0;
               if (clk_rise) begin
                  shift_1 <= {shift_1[FRAME_BITS-2:0], dat_1};
                  shift_2 <= {shift_2[FRAME_BITS-2:0], dat_2};
                  bit_cnt <= CNT_BITS'(1);
                  timer   <= TIMER_LOAD;
               end
               if (le_rise)       state <= ST_CLOSE;
               else if (clk_rise) state <= ST_SHIFT;
            end

            ST_SHIFT: begin
               if (clk_rise) begin
                  shift_1 <= {shift_1[FRAME_BITS-2:0], dat_1};
                  shift_2 <= {shift_2[FRAME_BITS-2:0], dat_2};
                  if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
                  timer <= TIMER_LOAD;
               end else if (timer != '0) begin
                  timer <= timer - 1'b1;
               end

               if (le_rise) begin
                  state <= ST_CLOSE;
               end else if (!clk_rise && timer == '0) begin
                  state   <= ST_IDLE;
                  bit_cnt <= '0;
               end
            end

            ST_CLOSE: begin
               state   <= ST_IDLE;
               bit_cnt <= '0;
               if (close_good) begin
                  if (!out_valid || out_ready) begin
                     sample_1  <= shift_1[SAMPLE_LSB +: SAMPLE_BITS];
                     sample_2  <= shift_2[SAMPLE_LSB +: SAMPLE_BITS];
                     cmd_1     <= shift_1[CMD_LSB +: CMD_BITS];
                     cmd_2     <= shift_2[CMD_LSB +: CMD_BITS];
                     out_valid <= 1'b1;
                  end
               end else begin
                  frame_err <= 1'b1;
               end
            end

            default: begin
               state   <= ST_IDLE;
               bit_cnt <= '0;
            end
         endcase

         if (clr_status)       overrun <= 1'b0;
         else if (overrun_set) overrun <= 1'b1;

         if (clr_status)                        err_count <= '0;
         else if (close_bad && err_count != '1) err_count <= err_count + 1'b1;
      end
   end

endmodule
